// File: rtl/scan_codes.sv
// PS/2 set-2 break-sequence decoder for the top-row digit keys 1..9,0.
// A recognised F0xx sequence produces a one-cycle strobe and loads the digit.
module scan_codes (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_code,
  input  logic        i_status,
  output logic        o_control,
  output logic [3:0]  o_num
);

  localparam int NUM_KEYS = 10;

  // Entry k holds the break sequence for digit (k+1) mod 10, i.e. keys 1..9 then 0.
  localparam logic [15:0] KEY_CODES [NUM_KEYS] = '{
    16'hF016, 16'hF01E, 16'hF026, 16'hF025, 16'hF02E,
    16'hF036, 16'hF03D, 16'hF03E, 16'hF046, 16'hF045
  };

  logic [NUM_KEYS-1:0] hit;
  logic [3:0]          digit_masked [NUM_KEYS];
  logic [3:0]          digit_any;
  logic                hit_any;

  logic                control_reg;
  logic                control_next;
  logic [3:0]          num_reg;
  logic [3:0]          num_next;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      localparam logic [3:0] DIGIT = 4'((gi + 1) % 10);
      assign hit[gi]          = (i_code == KEY_CODES[gi]);
      assign digit_masked[gi] = {4{hit[gi]}} & DIGIT;
    end
  endgenerate

  // Table entries are distinct, so at most one mask is non-zero and OR acts as a mux.
  always_comb begin
    digit_any = 4'd0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      digit_any = digit_any | digit_masked[k];
    end
    hit_any = |hit;
  end

  always_comb begin
    control_next = 1'b0;
    num_next     = num_reg;
    if (i_status && hit_any) begin
      control_next = 1'b1;
      num_next     = digit_any;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      control_reg <= 1'b0;
      num_reg     <= 4'd0;
    end else begin
      control_reg <= control_next;
      num_reg     <= num_next;
    end
  end

  assign o_control = control_reg;
  assign o_num     = num_reg;

endmodule

// File: tb/tb_scan_codes.sv
// Scoreboard bench for scan_codes: driver queues hand-computed responses,
// monitor checks them one clock after each applied vector.
module tb_scan_codes;

  logic        i_clk;
  logic        i_rst_n;
  logic [15:0] i_code;
  logic        i_status;
  logic        o_control;
  logic [3:0]  o_num;

  typedef struct packed {
    logic        rst_n;
    logic        status;
    logic [15:0] code;
    logic        ctrl;
    logic [3:0]  num;
  } txn_t;

  txn_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   txn_id = 0;
  bit   drive_done = 0;

  scan_codes dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_code    (i_code),
    .i_status  (i_status),
    .o_control (o_control),
    .o_num     (o_num)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic apply(input logic rst_n, input logic status, input logic [15:0] code,
                       input logic exp_ctrl, input logic [3:0] exp_num);
    txn_t t;
    @(negedge i_clk);
    i_rst_n  = rst_n;
    i_status = status;
    i_code   = code;
    t.rst_n  = rst_n;
    t.status = status;
    t.code   = code;
    t.ctrl   = exp_ctrl;
    t.num    = exp_num;
    exp_q.push_back(t);
  endtask

  // Driver
  initial begin
    i_rst_n  = 1'b0;
    i_status = 1'b0;
    i_code   = 16'h0000;
    // reset held for two edges
    apply(0, 0, 16'h0000, 0, 0);
    apply(0, 1, 16'hF016, 0, 0);
    // each digit followed by an idle edge
    apply(1, 1, 16'hF016, 1, 1);  apply(1, 0, 16'h0000, 0, 1);
    apply(1, 1, 16'hF01E, 1, 2);  apply(1, 0, 16'h0000, 0, 2);
    apply(1, 1, 16'hF026, 1, 3);  apply(1, 0, 16'h0000, 0, 3);
    apply(1, 1, 16'hF025, 1, 4);  apply(1, 0, 16'h0000, 0, 4);
    apply(1, 1, 16'hF02E, 1, 5);  apply(1, 0, 16'h0000, 0, 5);
    // non-table sequences leave o_num alone
    apply(1, 1, 16'h0016, 0, 5);
    apply(1, 1, 16'hF01C, 0, 5);
    apply(1, 1, 16'h16F0, 0, 5);
    apply(1, 1, 16'hE016, 0, 5);
    apply(1, 1, 16'hF036, 1, 6);  apply(1, 0, 16'h0000, 0, 6);
    apply(1, 1, 16'hF03D, 1, 7);  apply(1, 0, 16'h0000, 0, 7);
    apply(1, 1, 16'hF03E, 1, 8);  apply(1, 0, 16'h0000, 0, 8);
    apply(1, 1, 16'hF046, 1, 9);
    apply(1, 0, 16'hF016, 0, 9);  // code ignored while status low
    apply(1, 1, 16'hF045, 1, 0);  apply(1, 0, 16'h0000, 0, 0);
    // status held high: strobe every cycle
    apply(1, 1, 16'hF026, 1, 3);
    apply(1, 1, 16'hF026, 1, 3);
    apply(1, 1, 16'hF026, 1, 3);
    apply(1, 1, 16'hF01E, 1, 2);
    // reset wins over a valid code
    apply(0, 1, 16'hF036, 0, 0);
    apply(1, 1, 16'hF046, 1, 9);
    apply(0, 0, 16'h0000, 0, 0);
    apply(1, 0, 16'h0000, 0, 0);
    drive_done = 1;
  end

  // Monitor
  initial begin
    txn_t t;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
        t = exp_q.pop_front();
        txn_id++;
        checks++;
        $display("txn %0d rst_n=%b status=%b code=%h -> control=%b num=%0d (want %b/%0d)",
                 txn_id, t.rst_n, t.status, t.code, o_control, o_num, t.ctrl, t.num);
        if (o_control !== t.ctrl || o_num !== t.num) begin
          errors++;
          $display("FAIL txn%0d_outputs code=%h got control=%b num=%0d want control=%b num=%0d",
                   txn_id, t.code, o_control, o_num, t.ctrl, t.num);
        end
      end
    end
  end

  // Completion with bounded wait
  initial begin
    int cycles;
    cycles = 0;
    while (!(drive_done && exp_q.size() == 0) && cycles < 2000) begin
      @(posedge i_clk);
      cycles++;
    end
    if (cycles >= 2000) begin
      checks++;
      errors++;
      $display("FAIL timeout pending=%0d want pending=0", exp_q.size());
    end
    repeat (2) @(posedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
